pipe_skid_buffer: RTL

- Two-entry valid/ready pipeline slice (skid buffer) that breaks the combinational ready path between a producer and a consumer stage.
- Sits directly upstream of enable-gated pipeline registers. Its m_valid/m_ready handshake produces the per-stage load enable (en = m_valid & m_ready) and the data those registers capture.
- Full throughput (one transfer per cycle), one cycle of forward latency. s_ready is driven purely from registered state.

---
 rtl/pipe_skid_buffer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pipe_skid_buffer.sv
// Two-entry valid/ready skid buffer. Breaks the combinational ready path
// between a producer and a consumer while sustaining one transfer per cycle.
// m_data is driven straight from the main register so the downstream
// enable-gated stage (en = m_valid & m_ready) captures a registered value.
module pipe_skid_buffer #(
    parameter int unsigned           WIDTH     = 32,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StBusy  = 2'b01,
        StFull  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic             main_valid_q, main_valid_d;
    logic [1:0]       occ_q, occ_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;

    // Next-state, valid, occupancy and data-register selection.
    always_comb begin
        state_d      = state_q;
        main_valid_d = main_valid_q;
        occ_d        = occ_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            // Only the valids clear; data registers keep their contents.
            state_d      = StEmpty;
            main_valid_d = 1'b0;
            occ_d        = 2'd0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (s_valid) begin
                        main_data_d  = s_data;
                        main_valid_d = 1'b1;
                        occ_d        = 2'd1;
                        state_d      = StBusy;
                    end
                end
                StBusy: begin
                    if (s_valid && m_ready) begin
                        // Pass-through: downstream takes main, new beat replaces it.
                        main_data_d = s_data;
                    end else if (s_valid) begin
                        skid_data_d = s_data;
                        occ_d       = 2'd2;
                        state_d     = StFull;
                    end else if (m_ready) begin
                        main_valid_d = 1'b0;
                        occ_d        = 2'd0;
                        state_d      = StEmpty;
                    end
                end
                StFull: begin
                    // s_ready is low here, so s_valid is ignored.
                    if (m_ready) begin
                        main_data_d = skid_data_q;
                        occ_d       = 2'd1;
                        state_d     = StBusy;
                    end
                end
                default: begin
                    // Unused encoding: drop everything and restart empty.
                    main_valid_d = 1'b0;
                    occ_d        = 2'd0;
                    state_d      = StEmpty;
                end
            endcase
        end
    end

    // Control state: FSM, main valid and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StEmpty;
            main_valid_q <= 1'b0;
            occ_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            main_valid_q <= main_valid_d;
            occ_q        <= occ_d;
        end
    end

    // Payload registers; reset to a defined value so m_data never carries X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_q <= RESET_VAL;
            skid_data_q <= RESET_VAL;
        end else begin
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

    // Outputs come only from registered state; no path from m_ready to s_ready.
    always_comb begin
        s_ready   = (state_q != StFull);
        m_valid   = main_valid_q;
        m_data    = main_data_q;
        occupancy = occ_q;
    end

endmodule
